// File: rtl/reindeer_instruction_fetch.sv
// Instruction fetch stage: single-outstanding memory reads, redirect/squash handling, one beat per word to decode.
// Optional misaligned-redirect trap enabled by defining REINDEER_FETCH_MISALIGN_CHECK_EN.
module reindeer_instruction_fetch #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned PC_BITWIDTH = 32
) (
   input  logic                   clk,
   input  logic                   sync_reset,
   input  logic                   fetch_init,
   input  logic [PC_BITWIDTH-1:0] start_addr,
   input  logic                   fetch_enable,
   input  logic                   jump_active,
   input  logic [PC_BITWIDTH-1:0] jump_addr,
   output logic                   mem_read_req,
   output logic [PC_BITWIDTH-1:0] mem_read_addr,
   input  logic                   mem_read_ack,
   input  logic [XLEN-1:0]        mem_read_data,
   output logic                   enable_out,
   output logic [XLEN-1:0]        IR_out,
   output logic [PC_BITWIDTH-1:0] PC_out,
   output logic                   exception_instr_addr_misaligned
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t                 state_q, state_d;
   logic [PC_BITWIDTH-1:0] pc_q, pc_d;
   logic                   squash_q, squash_d;
   logic                   req_q, req_d;
   logic [PC_BITWIDTH-1:0] addr_q, addr_d;
   logic                   enable_q, enable_d;
   logic [XLEN-1:0]        ir_q, ir_d;
   logic [PC_BITWIDTH-1:0] pc_out_q, pc_out_d;

   logic                   redirect_c;
   logic [PC_BITWIDTH-1:0] target_c;
   logic                   load_pc_c;

   // Redirect decode: fetch_init wins over jump_active.
   always_comb begin
      redirect_c = fetch_init | jump_active;
      target_c   = fetch_init ? start_addr : jump_addr;
   end

`ifdef REINDEER_FETCH_MISALIGN_CHECK_EN
   logic misalign_c;
   logic exc_q, exc_d;

   always_comb begin
      misalign_c = redirect_c & (target_c[1:0] != 2'b00);
      load_pc_c  = redirect_c & ~misalign_c;
      exc_d      = misalign_c;
   end

   always_ff @(posedge clk) begin
      if (sync_reset) exc_q <= 1'b0;
      else            exc_q <= exc_d;
   end

   assign exception_instr_addr_misaligned = exc_q;
`else
   always_comb begin
      load_pc_c = redirect_c;
   end

   assign exception_instr_addr_misaligned = 1'b0;
`endif

   // Next-state and output logic.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      squash_d = squash_q;
      req_d    = req_q;
      addr_d   = addr_q;
      enable_d = 1'b0;
      ir_d     = ir_q;
      pc_out_d = pc_out_q;

      unique case (state_q)
         S_IDLE: begin
            if (redirect_c) begin
               if (load_pc_c) pc_d = target_c;
            end else if (fetch_enable) begin
               req_d   = 1'b1;
               addr_d  = pc_q;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_read_ack) begin
               req_d   = 1'b0;
               state_d = S_IDLE;
               if (!squash_q && !redirect_c) begin
                  ir_d     = mem_read_data;
                  pc_out_d = addr_q;
                  enable_d = 1'b1;
                  pc_d     = addr_q + PC_BITWIDTH'(4);
               end else begin
                  squash_d = 1'b0;
                  if (load_pc_c) pc_d = target_c;
               end
            end else if (redirect_c) begin
               // Request stays up; the returning word is dropped later.
               squash_d = 1'b1;
               if (load_pc_c) pc_d = target_c;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         squash_q <= 1'b0;
         req_q    <= 1'b0;
         addr_q   <= '0;
         enable_q <= 1'b0;
         ir_q     <= '0;
         pc_out_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         squash_q <= squash_d;
         req_q    <= req_d;
         addr_q   <= addr_d;
         enable_q <= enable_d;
         ir_q     <= ir_d;
         pc_out_q <= pc_out_d;
      end
   end

   assign mem_read_req  = req_q;
   assign mem_read_addr = addr_q;
   assign enable_out    = enable_q;
   assign IR_out        = ir_q;
   assign PC_out        = pc_out_q;

endmodule

// File: tb/tb_reindeer_instruction_fetch.sv
// Directed bench for reindeer_instruction_fetch; honours REINDEER_FETCH_MISALIGN_CHECK_EN for the misaligned-redirect step.
module tb_reindeer_instruction_fetch;

   logic        clk = 1'b0;
   logic        sync_reset, fetch_init, fetch_enable, jump_active, mem_read_ack;
   logic [31:0] start_addr, jump_addr, mem_read_data;
   logic        mem_read_req, enable_out, exc;
   logic [31:0] mem_read_addr, IR_out, PC_out;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   reindeer_instruction_fetch #(.XLEN(32), .PC_BITWIDTH(32)) dut (
      .clk                            (clk),
      .sync_reset                     (sync_reset),
      .fetch_init                     (fetch_init),
      .start_addr                     (start_addr),
      .fetch_enable                   (fetch_enable),
      .jump_active                    (jump_active),
      .jump_addr                      (jump_addr),
      .mem_read_req                   (mem_read_req),
      .mem_read_addr                  (mem_read_addr),
      .mem_read_ack                   (mem_read_ack),
      .mem_read_data                  (mem_read_data),
      .enable_out                     (enable_out),
      .IR_out                         (IR_out),
      .PC_out                         (PC_out),
      .exception_instr_addr_misaligned(exc)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      sync_reset = 1'b1; fetch_init = 1'b0; start_addr = '0; fetch_enable = 1'b0;
      jump_active = 1'b0; jump_addr = '0; mem_read_ack = 1'b0; mem_read_data = '0;
      tick(); tick();
      check("rst_req", 32'(mem_read_req), 32'd0);
      check("rst_addr", mem_read_addr, 32'h0);
      check("rst_en", 32'(enable_out), 32'd0);
      check("rst_ir", IR_out, 32'h0);
      check("rst_pc_out", PC_out, 32'h0);
      check("rst_exc", 32'(exc), 32'd0);

      // Boot at 0x80, one-cycle memory
      sync_reset = 1'b0; fetch_init = 1'b1; start_addr = 32'h80;
      tick();
      check("init_no_req", 32'(mem_read_req), 32'd0);
      fetch_init = 1'b0; fetch_enable = 1'b1;
      tick();
      check("boot_req", 32'(mem_read_req), 32'd1);
      check("boot_addr", mem_read_addr, 32'h80);
      fetch_enable = 1'b0; mem_read_ack = 1'b1; mem_read_data = 32'h00000013;
      tick();
      check("boot_en", 32'(enable_out), 32'd1);
      check("boot_ir", IR_out, 32'h00000013);
      check("boot_pc_out", PC_out, 32'h80);
      check("boot_req_drop", 32'(mem_read_req), 32'd0);
      mem_read_ack = 1'b0; fetch_enable = 1'b1;
      tick();
      check("en_one_cycle", 32'(enable_out), 32'd0);
      check("next_req", 32'(mem_read_req), 32'd1);
      check("next_addr", mem_read_addr, 32'h84);

      // Variable latency: request held while ack is late
      fetch_enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("hold_req", 32'(mem_read_req), 32'd1);
         check("hold_addr", mem_read_addr, 32'h84);
         check("hold_no_en", 32'(enable_out), 32'd0);
      end
      mem_read_ack = 1'b1; mem_read_data = 32'h00100093;
      tick();
      check("late_en", 32'(enable_out), 32'd1);
      check("late_ir", IR_out, 32'h00100093);
      check("late_pc_out", PC_out, 32'h84);
      mem_read_ack = 1'b0;
      tick();
      check("late_single_en", 32'(enable_out), 32'd0);
      check("late_no_extra_req", 32'(mem_read_req), 32'd0);

      // Squash: jump two cycles into WAIT
      fetch_enable = 1'b1;
      tick();
      check("sq_addr", mem_read_addr, 32'h88);
      fetch_enable = 1'b0;
      tick();
      jump_active = 1'b1; jump_addr = 32'h200;
      tick();
      check("sq_req_kept", 32'(mem_read_req), 32'd1);
      check("sq_addr_kept", mem_read_addr, 32'h88);
      jump_active = 1'b0; mem_read_ack = 1'b1; mem_read_data = 32'hDEADBEEF;
      tick();
      check("sq_no_en", 32'(enable_out), 32'd0);
      check("sq_ir_kept", IR_out, 32'h00100093);
      check("sq_req_drop", 32'(mem_read_req), 32'd0);
      mem_read_ack = 1'b0; fetch_enable = 1'b1;
      tick();
      check("sq_new_addr", mem_read_addr, 32'h200);

      // Same-cycle ack and jump
      fetch_enable = 1'b0; mem_read_ack = 1'b1; mem_read_data = 32'h11111111;
      jump_active = 1'b1; jump_addr = 32'h300;
      tick();
      check("sc_no_en", 32'(enable_out), 32'd0);
      check("sc_ir_kept", IR_out, 32'h00100093);
      check("sc_pc_out_kept", PC_out, 32'h84);
      mem_read_ack = 1'b0; jump_active = 1'b0; fetch_enable = 1'b1;
      tick();
      check("sc_new_addr", mem_read_addr, 32'h300);
      fetch_enable = 1'b0; mem_read_ack = 1'b1; mem_read_data = 32'h22222222;
      tick();
      check("sc_after_en", 32'(enable_out), 32'd1);
      check("sc_after_ir", IR_out, 32'h22222222);
      check("sc_after_pc_out", PC_out, 32'h300);

      // fetch_init beats jump_active inside WAIT
      mem_read_ack = 1'b0; fetch_enable = 1'b1;
      tick();
      check("prio_addr", mem_read_addr, 32'h304);
      fetch_enable = 1'b0; fetch_init = 1'b1; start_addr = 32'h500;
      jump_active = 1'b1; jump_addr = 32'h600;
      tick();
      fetch_init = 1'b0; jump_active = 1'b0; mem_read_ack = 1'b1; mem_read_data = 32'h55555555;
      tick();
      check("prio_no_en", 32'(enable_out), 32'd0);
      mem_read_ack = 1'b0; fetch_enable = 1'b1;
      tick();
      check("prio_new_addr", mem_read_addr, 32'h500);

      // Synchronous reset mid-WAIT
      fetch_enable = 1'b0; sync_reset = 1'b1;
      tick();
      check("mid_rst_req", 32'(mem_read_req), 32'd0);
      check("mid_rst_addr", mem_read_addr, 32'h0);
      check("mid_rst_ir", IR_out, 32'h0);
      check("mid_rst_pc_out", PC_out, 32'h0);

      // PC wrap at top of address space
      sync_reset = 1'b0; fetch_init = 1'b1; start_addr = 32'hFFFFFFFC;
      tick();
      fetch_init = 1'b0; fetch_enable = 1'b1;
      tick();
      check("wrap_addr", mem_read_addr, 32'hFFFFFFFC);
      fetch_enable = 1'b0; mem_read_ack = 1'b1; mem_read_data = 32'h00000033;
      tick();
      check("wrap_pc_out", PC_out, 32'hFFFFFFFC);
      check("wrap_en", 32'(enable_out), 32'd1);
      mem_read_ack = 1'b0; fetch_enable = 1'b1;
      tick();
      check("wrap_next_addr", mem_read_addr, 32'h0);

      // Ack in IDLE is ignored
      fetch_enable = 1'b0; mem_read_ack = 1'b1; mem_read_data = 32'h00000044;
      tick();
      check("idle_pre_ir", IR_out, 32'h00000044);
      mem_read_data = 32'h99999999;
      tick();
      check("idle_ack_no_en", 32'(enable_out), 32'd0);
      check("idle_ack_ir", IR_out, 32'h00000044);
      check("idle_ack_no_req", 32'(mem_read_req), 32'd0);
      mem_read_ack = 1'b0;

      // Misaligned redirect in IDLE (PC is 0x4 here)
      jump_active = 1'b1; jump_addr = 32'h102;
      tick();
`ifdef REINDEER_FETCH_MISALIGN_CHECK_EN
      check("mis_exc", 32'(exc), 32'd1);
`else
      check("mis_exc", 32'(exc), 32'd0);
`endif
      jump_active = 1'b0;
      tick();
      check("mis_exc_one_cycle", 32'(exc), 32'd0);
      fetch_enable = 1'b1;
      tick();
`ifdef REINDEER_FETCH_MISALIGN_CHECK_EN
      check("mis_addr", mem_read_addr, 32'h4);
`else
      check("mis_addr", mem_read_addr, 32'h102);
`endif
      fetch_enable = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
